fact_accel_mmio: RTL

- Memory-mapped factorial accelerator. Sits directly downstream of the SoC address decoder.
- Consumes the decoder's factorial write-enable (WE1) and returns read data, which the decoder's RdSel=2'b10 path selects onto the CPU read bus.
- Occupies 0x100–0x10F. A[3:2] selects one of four word registers; iterative multiply FSM computes n!.

---
 rtl/fact_pkg.sv | 25 ++
 rtl/fact_core.sv | 116 +++++++++++
 rtl/fact_accel_mmio.sv | 86 ++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// ============================================================================
//  fact_pkg : shared register offsets, FSM encoding and limits for fact_accel_mmio
//  Rev 1.0
// ============================================================================
`default_nettype none

package fact_pkg;

   localparam logic [1:0] FACT_N      = 2'b00;
   localparam logic [1:0] FACT_GO     = 2'b01;
   localparam logic [1:0] FACT_STATUS = 2'b10;
   localparam logic [1:0] FACT_RESULT = 2'b11;

   localparam int FACT_MAX_N = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_MUL  = 2'b10,
      ST_DONE = 2'b11
   } fact_state_t;

endpackage

`default_nettype wire

// File: rtl/fact_core.sv
// ============================================================================
//  fact_core : iterative n! engine (FSM, down-counter, product and sticky flags)
//  Optional FACT_ACCEL_IRQ_EN adds in_done_o marking the DONE state.  Rev 1.0
// ============================================================================
`default_nettype none

module fact_core
   import fact_pkg::*;
#(
   parameter int N_WIDTH    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_N      = FACT_MAX_N
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N_WIDTH-1:0]    n,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] result
`ifdef FACT_ACCEL_IRQ_EN
   ,
   output logic                  in_done_o
`endif
);

   localparam logic [N_WIDTH-1:0]    c_max_n = N_WIDTH'(MAX_N);
   localparam logic [N_WIDTH-1:0]    c_one_n = N_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] c_one_d = DATA_WIDTH'(1);

   fact_state_t           state_q, state_d;
   logic [N_WIDTH-1:0]    cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] product_q, product_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] w_prod;

   // Low DATA_WIDTH bits only; no overflow can occur for n <= MAX_N.
   assign w_prod = product_q * DATA_WIDTH'(cnt_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         product_q <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         result_q  <= result_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      result_d  = result_q;
      done_d    = done_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            cnt_d     = n;
            product_d = c_one_d;
            if (n > c_max_n) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = ST_DONE;
            end else begin
               state_d  = ST_MUL;
            end
         end
         ST_MUL: begin
            if (cnt_q > c_one_n) begin
               product_d = w_prod;
               cnt_d     = cnt_q - c_one_n;
            end else begin
               result_d = product_q;
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            // The error path reaches here without done set; raise it now.
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;
`ifdef FACT_ACCEL_IRQ_EN
   assign in_done_o = (state_q == ST_DONE);
`endif

endmodule

`default_nettype wire

// File: rtl/fact_accel_mmio.sv
// ============================================================================
//  fact_accel_mmio : memory-mapped factorial accelerator (N, GO, STATUS, RESULT)
//  Optional FACT_ACCEL_IRQ_EN adds a one-cycle completion irq.  Rev 1.0
// ============================================================================
`default_nettype none

module fact_accel_mmio
   import fact_pkg::*;
#(
   parameter int N_WIDTH    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_N      = FACT_MAX_N
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WE,
   input  logic [1:0]            A,
   input  logic [DATA_WIDTH-1:0] WD,
   output logic [DATA_WIDTH-1:0] RD
`ifdef FACT_ACCEL_IRQ_EN
   ,
   output logic                  irq
`endif
);

   logic [N_WIDTH-1:0]    n_q, n_d;
   logic                  w_start;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_err;
   logic [DATA_WIDTH-1:0] w_result;
   logic                  w_unused_wd;

   assign w_unused_wd = ^WD;

   // The core only honours start in IDLE, so GO while busy is dropped there.
   assign w_start = WE && (A == FACT_GO) && WD[0];

   always_comb begin
      n_d = n_q;
      if (WE && (A == FACT_N)) begin
         n_d = WD[N_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q <= '0;
      end else begin
         n_q <= n_d;
      end
   end

   fact_core #(
      .N_WIDTH    (N_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_N      (MAX_N)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .start  (w_start),
      .n      (n_q),
      .busy   (w_busy),
      .done   (w_done),
      .err    (w_err),
      .result (w_result)
`ifdef FACT_ACCEL_IRQ_EN
      ,
      .in_done_o (irq)
`endif
   );

   always_comb begin
      RD = '0;
      case (A)
         FACT_N:      RD = {{(DATA_WIDTH-N_WIDTH){1'b0}}, n_q};
         FACT_GO:     RD = {{(DATA_WIDTH-1){1'b0}}, w_busy};
         FACT_STATUS: RD = {{(DATA_WIDTH-2){1'b0}}, w_err, w_done};
         FACT_RESULT: RD = w_result;
         default:     RD = '0;
      endcase
   end

endmodule

`default_nettype wire
